// File: rtl/cross_sum_sequencer_pkg.sv
// Shared definitions for the sequential cross-sum datapath: FSM states,
// term/product counts and the index width of the operand selectors.
package cross_sum_sequencer_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_TERMS    = 4;
    localparam int N_PRODUCTS = 16;
    localparam int IDX_W      = 2;

    localparam logic [IDX_W-1:0] IDX_LAST = 2'd3;

    // True when the selected pair is the final product x3*y3
    function automatic logic is_last_pair(
        input logic [IDX_W-1:0] i_idx,
        input logic [IDX_W-1:0] j_idx
    );
        return (i_idx == IDX_LAST) && (j_idx == IDX_LAST);
    endfunction

endpackage

// File: rtl/cross_sum_sequencer_mac_unit.sv
// Single multiply-accumulate slice shared by all 16 cross products.
// The accumulator is registered; its next value is exported so the owner
// can latch the final total on the same edge that the last product lands.
module mac_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_acc_nxt
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_acc_nxt;

    // Truncated product and modulo-2^WIDTH next accumulator value
    always_comb begin
        w_prod = i_a * i_b;
        if (i_clr) begin
            w_acc_nxt = {WIDTH{1'b0}};
        end else if (i_en) begin
            w_acc_nxt = r_acc + w_prod;
        end else begin
            w_acc_nxt = r_acc;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= {WIDTH{1'b0}};
        end else begin
            r_acc <= w_acc_nxt;
        end
    end

    assign o_acc_nxt = w_acc_nxt;

endmodule

// File: rtl/cross_sum_sequencer.sv
// Sequential cross-sum: (x0+x1+x2+x3)*(y0+y1+y2+y3) evaluated as 16
// pairwise products through one shared MAC, i-major order x0y0..x3y3.
// Operands are captured once on accept; the result is held in DONE until
// the consumer takes it.
module cross_sum_sequencer
    import cross_sum_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] c1,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] b2,
    input  logic [WIDTH-1:0] c2,
    input  logic [WIDTH-1:0] d2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_x [N_TERMS];
    logic [WIDTH-1:0] r_y [N_TERMS];
    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;

    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [WIDTH-1:0] r_sum;

    logic             w_accept;
    logic             w_run_en;
    logic             w_last;
    logic [WIDTH-1:0] w_x_sel;
    logic [WIDTH-1:0] w_y_sel;
    logic [WIDTH-1:0] w_acc_nxt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_run_en    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                w_run_en = 1'b1;
                if (is_last_pair(r_i, r_j)) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Handshake/status flags registered from the upcoming state so they
    // line up exactly with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt == RUN);
        end
    end

    // Operand capture on accept only; later input changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_TERMS; k++) begin
                r_x[k] <= {WIDTH{1'b0}};
                r_y[k] <= {WIDTH{1'b0}};
            end
        end else if (w_accept) begin
            r_x[0] <= a1;
            r_x[1] <= b1;
            r_x[2] <= c1;
            r_x[3] <= d1;
            r_y[0] <= a2;
            r_y[1] <= b2;
            r_y[2] <= c2;
            r_y[3] <= d2;
        end else begin
            for (int k = 0; k < N_TERMS; k++) begin
                r_x[k] <= r_x[k];
                r_y[k] <= r_y[k];
            end
        end
    end

    // Pair indices: {i,j} as one 4-bit counter gives i-major order and
    // natural wrap of j into i
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i <= {IDX_W{1'b0}};
            r_j <= {IDX_W{1'b0}};
        end else if (w_accept) begin
            r_i <= {IDX_W{1'b0}};
            r_j <= {IDX_W{1'b0}};
        end else if (w_run_en) begin
            {r_i, r_j} <= {r_i, r_j} + {{(2*IDX_W-1){1'b0}}, 1'b1};
        end else begin
            r_i <= r_i;
            r_j <= r_j;
        end
    end

    // Operand selection for the shared MAC
    always_comb begin
        w_x_sel = r_x[r_i];
        w_y_sel = r_y[r_j];
    end

    mac_unit #(
        .WIDTH (WIDTH)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_accept),
        .i_en      (w_run_en),
        .i_a       (w_x_sel),
        .i_b       (w_y_sel),
        .o_acc_nxt (w_acc_nxt)
    );

    // Result latch: loaded with the total including the last product on
    // DONE entry, otherwise held across IDLE and the next RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= {WIDTH{1'b0}};
        end else if (w_last) begin
            r_sum <= w_acc_nxt;
        end else begin
            r_sum <= r_sum;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;

endmodule

// File: tb/tb_cross_sum_sequencer.sv
// Directed bench for cross_sum_sequencer: reset values, latency, busy
// width, arithmetic incl. wrap, backpressure, mid-run reset, back-to-back.
module tb_cross_sum_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a1, b1, c1, d1, a2, b2, c2, d2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        busy;

    int n_checks;
    int n_errors;

    cross_sum_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a1        (a1),
        .b1        (b1),
        .c1        (c1),
        .d1        (d1),
        .a2        (a2),
        .b2        (b2),
        .c2        (c2),
        .d2        (d2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_sum(
        input logic [31:0] x0, x1, x2, x3, y0, y1, y2, y3
    );
        logic [31:0] xs [4];
        logic [31:0] ys [4];
        logic [31:0] acc;
        logic [31:0] p;
        xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
        ys[0] = y0; ys[1] = y1; ys[2] = y2; ys[3] = y3;
        acc = 32'd0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                p   = xs[i] * ys[j];
                acc = acc + p;
            end
        end
        return acc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [31:0] x0, x1, x2, x3, y0, y1, y2, y3);
        a1 = x0; b1 = x1; c1 = x2; d1 = x3;
        a2 = y0; b2 = y1; c2 = y2; d2 = y3;
    endtask

    // One full transaction; operands are scrambled right after accept
    task automatic do_txn(input string tag,
                          input logic [31:0] x0, x1, x2, x3, y0, y1, y2, y3,
                          input logic [31:0] exp, input bit hold_bp);
        int w;
        int cyc;
        int bcnt;
        set_ops(x0, x1, x2, x3, y0, y1, y2, y3);
        in_valid  = 1'b1;
        out_ready = !hold_bp;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        set_ops($urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom);
        cyc  = 0;
        bcnt = 0;
        while (!out_valid && cyc < 40) begin
            if (busy) bcnt++;
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd16);
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'd16);
        check({tag, "_sum"}, sum, exp);
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        if (hold_bp) begin
            for (int k = 0; k < 5; k++) begin
                tick();
                check({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_bp_sum"}, sum, exp);
                check({tag, "_bp_in_ready"}, 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
        end
        tick();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_sum_retained"}, sum, exp);
    endtask

    initial begin
        int acc_idx [2];
        logic [31:0] res [2];
        int nacc;
        int nres;
        bit acc_now;
        bit hs_now;
        logic [31:0] smp;
        logic [31:0] rx [8];

        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_ops(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Reset state
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", sum, 32'd0);
        rst = 1'b0;
        tick();

        // All ones -> 16
        do_txn("ones", 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd16, 1'b0);

        // Distinct values -> 10*26 = 260, also against the reference model
        check("ref_model_260", ref_sum(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8), 32'd260);
        do_txn("distinct", 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd260, 1'b0);

        // Product truncation: 0xFFFFFFFF*2 -> 0xFFFFFFFE
        do_txn("ovf_prod", 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd2, 32'd0, 32'd0, 32'd0,
               32'hFFFF_FFFE, 1'b0);
        // Every product 2^32 wraps to zero
        do_txn("ovf_zero", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
               32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0);

        // Backpressure held 5 cycles in DONE: (2+3+4+5)*(1+1+1+1) = 56
        do_txn("backpressure", 32'd2, 32'd3, 32'd4, 32'd5, 32'd1, 32'd1, 32'd1, 32'd1, 32'd56, 1'b1);

        // Random operands against the reference model
        for (int k = 0; k < 8; k++) rx[k] = $urandom;
        do_txn("random", rx[0], rx[1], rx[2], rx[3], rx[4], rx[5], rx[6], rx[7],
               ref_sum(rx[0], rx[1], rx[2], rx[3], rx[4], rx[5], rx[6], rx[7]), 1'b0);

        // Reset 8 cycles into RUN aborts immediately
        set_ops(32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        check("midrun_busy_before", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_in_ready", 32'(in_ready), 32'd1);
        check("midrun_out_valid", 32'(out_valid), 32'd0);
        check("midrun_busy", 32'(busy), 32'd0);
        check("midrun_sum", sum, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        do_txn("after_reset", 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd260, 1'b0);

        // Back-to-back with in_valid held high and two sets queued
        set_ops(32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1);
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        nacc       = 0;
        nres       = 0;
        acc_idx[0] = 0;
        acc_idx[1] = 0;
        res[0]     = 32'd0;
        res[1]     = 32'd0;
        for (int e = 0; e < 80 && nres < 2; e++) begin
            acc_now = in_valid && in_ready;
            hs_now  = out_valid && out_ready;
            smp     = sum;
            tick();
            if (acc_now) begin
                if (nacc < 2) acc_idx[nacc] = e;
                nacc++;
                if (nacc == 1) begin
                    set_ops(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (hs_now) begin
                if (nres < 2) res[nres] = smp;
                nres++;
            end
        end
        check("b2b_accepts", 32'(nacc), 32'd2);
        check("b2b_results", 32'(nres), 32'd2);
        check("b2b_accept_spacing", 32'(acc_idx[1] - acc_idx[0]), 32'd18);
        check("b2b_first_sum", res[0], 32'd16);
        check("b2b_second_sum", res[1], 32'd260);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
